// File: rtl/cu_dispatch_pkg.sv
// Shared definitions for the wavefront dispatcher: tag layout, FSM
// encoding, latched descriptor layout and tag pack/unpack helpers.
package cu_dispatch_pkg;

  localparam int WG_ID_W  = 11;
  localparam int WF_IDX_W = 4;
  localparam int TAG_W    = WG_ID_W + WF_IDX_W;
  localparam int WF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_GAP      = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [WG_ID_W-1:0]  wg_id;
    logic [WF_CNT_W-1:0] wf_count;
    logic [31:0]         start_pc;
    logic [9:0]          vgpr_base;
    logic [8:0]          sgpr_base;
    logic [15:0]         lds_base;
    logic [5:0]          wf_size;
    logic [9:0]          vgpr_stride;
    logic [8:0]          sgpr_stride;
  } wg_desc_t;

  // Build a wavefront tag from its workgroup id and index within the group.
  function automatic logic [TAG_W-1:0] pack_tag(input logic [WG_ID_W-1:0] wg_id,
                                                input logic [WF_IDX_W-1:0] wf_idx);
    return {wg_id, wf_idx};
  endfunction

  // Workgroup id carried in the upper bits of a tag.
  function automatic logic [WG_ID_W-1:0] tag_wg_id(input logic [TAG_W-1:0] tag);
    return tag[TAG_W-1:WF_IDX_W];
  endfunction

  // Wavefront index carried in the lower bits of a tag.
  function automatic logic [WF_IDX_W-1:0] tag_wf_idx(input logic [TAG_W-1:0] tag);
    return tag[WF_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/wg_track_cam.sv
// In-flight workgroup tracker: a small CAM of {valid, wg_id, remaining}
// entries with lowest-free allocation, done-tag matching, free-on-zero and a
// registered workgroup-complete pulse.
module wg_track_cam
  import cu_dispatch_pkg::*;
#(
  parameter int NUM_WG_SLOTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [WG_ID_W-1:0]  alloc_id,
  input  logic [WF_CNT_W-1:0] alloc_count,
  input  logic [WG_ID_W-1:0]  query_id,
  output logic                has_free,
  output logic                id_present,
  input  logic                done_en,
  input  logic [WG_ID_W-1:0]  done_id,
  output logic                done_hit,
  output logic                wg_done,
  output logic [WG_ID_W-1:0]  wg_done_id
);

  localparam int IDX_W = (NUM_WG_SLOTS > 1) ? $clog2(NUM_WG_SLOTS) : 1;

  logic [NUM_WG_SLOTS-1:0] valid_q, valid_d;
  logic [WG_ID_W-1:0]      id_q  [NUM_WG_SLOTS];
  logic [WG_ID_W-1:0]      id_d  [NUM_WG_SLOTS];
  logic [WF_CNT_W-1:0]     rem_q [NUM_WG_SLOTS];
  logic [WF_CNT_W-1:0]     rem_d [NUM_WG_SLOTS];
  logic                    wg_done_q, wg_done_d;
  logic [WG_ID_W-1:0]      wg_done_id_q, wg_done_id_d;

  logic [IDX_W-1:0]        alloc_idx_s;
  logic [NUM_WG_SLOTS-1:0] done_match_s;

  // Associative lookups: lowest free entry, id already in flight, done match.
  always_comb begin
    has_free     = 1'b0;
    alloc_idx_s  = '0;
    id_present   = 1'b0;
    done_match_s = '0;
    for (int i = NUM_WG_SLOTS - 1; i >= 0; i--) begin
      has_free        = has_free | ~valid_q[i];
      alloc_idx_s     = valid_q[i] ? alloc_idx_s : IDX_W'(i);
      id_present      = id_present | (valid_q[i] & (id_q[i] == query_id));
      done_match_s[i] = valid_q[i] & (id_q[i] == done_id);
    end
    done_hit = done_en & (|done_match_s);
  end

  // Entry updates: decrement on done, free on last done, allocate on accept.
  always_comb begin
    valid_d      = valid_q;
    id_d         = id_q;
    rem_d        = rem_q;
    wg_done_d    = 1'b0;
    wg_done_id_d = wg_done_id_q;
    for (int i = 0; i < NUM_WG_SLOTS; i++) begin
      if (done_en && done_match_s[i]) begin
        rem_d[i] = rem_q[i] - 4'd1;
        if (rem_q[i] == 4'd1) begin
          valid_d[i]   = 1'b0;
          wg_done_d    = 1'b1;
          wg_done_id_d = id_q[i];
        end else begin
          valid_d[i] = valid_q[i];
        end
      end else if (alloc_en && (alloc_idx_s == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
        id_d[i]    = alloc_id;
        rem_d[i]   = alloc_count;
      end else begin
        rem_d[i] = rem_q[i];
      end
    end
  end

  // CAM storage and the registered completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      wg_done_q    <= 1'b0;
      wg_done_id_q <= '0;
      for (int i = 0; i < NUM_WG_SLOTS; i++) begin
        id_q[i]  <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      wg_done_q    <= wg_done_d;
      wg_done_id_q <= wg_done_id_d;
      for (int i = 0; i < NUM_WG_SLOTS; i++) begin
        id_q[i]  <= id_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign wg_done    = wg_done_q;
  assign wg_done_id = wg_done_id_q;

endmodule

// File: rtl/cu_wf_dispatcher.sv
// Wavefront dispatcher for one compute unit: accepts workgroup descriptors,
// emits one dispatch pulse per wavefront, tracks CU wavefront credits and
// reports workgroup completion from returning done tags.
module cu_wf_dispatcher
  import cu_dispatch_pkg::*;
#(
  parameter int NUM_WG_SLOTS = 4,
  parameter int NUM_WF_SLOTS = 40,
  parameter int DISPATCH_GAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wg_valid,
  output logic                wg_ready,
  input  logic [WG_ID_W-1:0]  wg_id,
  input  logic [WF_CNT_W-1:0] wg_wf_count,
  input  logic [31:0]         wg_start_pc,
  input  logic [9:0]          wg_vgpr_base,
  input  logic [8:0]          wg_sgpr_base,
  input  logic [15:0]         wg_lds_base,
  input  logic [5:0]          wg_wf_size,
  input  logic [9:0]          wg_vgpr_stride,
  input  logic [8:0]          wg_sgpr_stride,
  output logic                dispatch2cu_wf_dispatch,
  output logic [TAG_W-1:0]    dispatch2cu_wf_tag_dispatch,
  output logic [31:0]         dispatch2cu_start_pc_dispatch,
  output logic [9:0]          dispatch2cu_vgpr_base_dispatch,
  output logic [8:0]          dispatch2cu_sgpr_base_dispatch,
  output logic [15:0]         dispatch2cu_lds_base_dispatch,
  output logic [5:0]          dispatch2cu_wf_size_dispatch,
  output logic [WF_CNT_W-1:0] dispatch2cu_wg_wf_count,
  input  logic                cu2dispatch_wf_done,
  input  logic [TAG_W-1:0]    cu2dispatch_wf_tag_done,
  output logic                wg_done,
  output logic [WG_ID_W-1:0]  wg_done_id,
  output logic [5:0]          free_wf_slots,
  output logic [1:0]          err_flags
);

  localparam logic [2:0] GAP_LOAD   = (DISPATCH_GAP > 0) ? 3'(DISPATCH_GAP - 1) : 3'd0;
  localparam logic [5:0] WF_CREDITS = 6'(NUM_WF_SLOTS);

  disp_state_e         state_q, state_d;
  logic [WF_IDX_W-1:0] wf_idx_q, wf_idx_d;
  logic [2:0]          gap_cnt_q, gap_cnt_d;
  logic                last_sent_q, last_sent_d;
  wg_desc_t            desc_q, desc_d;

  logic                disp_q, disp_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [31:0]         pc_q, pc_d;
  logic [9:0]          vgpr_q, vgpr_d;
  logic [8:0]          sgpr_q, sgpr_d;
  logic [15:0]         lds_q, lds_d;
  logic [5:0]          size_q, size_d;
  logic [WF_CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]          free_q, free_d;
  logic [1:0]          err_q, err_d;

  wg_desc_t            in_desc_s;
  logic                accept_s;
  logic                alloc_en_s;
  logic                last_wf_s;
  logic                cam_has_free_s;
  logic                cam_id_present_s;
  logic                cam_done_hit_s;
  logic                unused_tag_idx_s;

  // The wavefront index of a returning tag is not needed for bookkeeping.
  assign unused_tag_idx_s = ^tag_wf_idx(cu2dispatch_wf_tag_done);

  assign in_desc_s = '{
    wg_id:       wg_id,
    wf_count:    wg_wf_count,
    start_pc:    wg_start_pc,
    vgpr_base:   wg_vgpr_base,
    sgpr_base:   wg_sgpr_base,
    lds_base:    wg_lds_base,
    wf_size:     wg_wf_size,
    vgpr_stride: wg_vgpr_stride,
    sgpr_stride: wg_sgpr_stride
  };

  // Ready depends only on state and the offered descriptor, never on valid.
  assign wg_ready = (state_q == ST_IDLE) && cam_has_free_s &&
                    (free_q >= {2'b00, wg_wf_count}) && !cam_id_present_s;
  assign accept_s   = wg_valid & wg_ready;
  assign alloc_en_s = accept_s & (wg_wf_count != 4'd0);
  assign last_wf_s  = (wf_idx_q == (desc_q.wf_count - 4'd1));

  wg_track_cam #(
    .NUM_WG_SLOTS(NUM_WG_SLOTS)
  ) u_cam (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en_s),
    .alloc_id   (wg_id),
    .alloc_count(wg_wf_count),
    .query_id   (wg_id),
    .has_free   (cam_has_free_s),
    .id_present (cam_id_present_s),
    .done_en    (cu2dispatch_wf_done),
    .done_id    (tag_wg_id(cu2dispatch_wf_tag_done)),
    .done_hit   (cam_done_hit_s),
    .wg_done    (wg_done),
    .wg_done_id (wg_done_id)
  );

  // Dispatch sequencer: next state, next wavefront and the registered bus.
  always_comb begin
    state_d     = state_q;
    wf_idx_d    = wf_idx_q;
    gap_cnt_d   = gap_cnt_q;
    last_sent_d = last_sent_q;
    desc_d      = desc_q;
    disp_d      = 1'b0;
    tag_d       = tag_q;
    pc_d        = pc_q;
    vgpr_d      = vgpr_q;
    sgpr_d      = sgpr_q;
    lds_d       = lds_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (wg_wf_count == 4'd0) begin
            err_d[1] = 1'b1;
          end else begin
            desc_d      = in_desc_s;
            wf_idx_d    = 4'd0;
            last_sent_d = 1'b0;
            state_d     = ST_DISPATCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        disp_d = 1'b1;
        tag_d  = pack_tag(desc_q.wg_id, wf_idx_q);
        pc_d   = desc_q.start_pc;
        vgpr_d = desc_q.vgpr_base + 10'({6'd0, wf_idx_q} * desc_q.vgpr_stride);
        sgpr_d = desc_q.sgpr_base + 9'({5'd0, wf_idx_q} * desc_q.sgpr_stride);
        lds_d  = desc_q.lds_base;
        size_d = desc_q.wf_size;
        cnt_d  = desc_q.wf_count;
        if (last_wf_s) begin
          last_sent_d = 1'b1;
        end else begin
          wf_idx_d = wf_idx_q + 4'd1;
        end
        if (DISPATCH_GAP == 0) begin
          state_d = last_wf_s ? ST_IDLE : ST_DISPATCH;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 3'd0) begin
          state_d = last_sent_q ? ST_IDLE : ST_DISPATCH;
        end else begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (cu2dispatch_wf_done && !cam_done_hit_s) begin
      err_d[0] = 1'b1;
    end else begin
      err_d[0] = err_q[0];
    end
  end

  // Credits: one consumed per pulse, one returned per matched done.
  always_comb begin
    free_d = free_q - {5'd0, disp_d} + {5'd0, cam_done_hit_s};
  end

  // Sequencer state, registered dispatch bus, credits and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wf_idx_q    <= '0;
      gap_cnt_q   <= '0;
      last_sent_q <= 1'b0;
      desc_q      <= '0;
      disp_q      <= 1'b0;
      tag_q       <= '0;
      pc_q        <= '0;
      vgpr_q      <= '0;
      sgpr_q      <= '0;
      lds_q       <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      free_q      <= WF_CREDITS;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wf_idx_q    <= wf_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      last_sent_q <= last_sent_d;
      desc_q      <= desc_d;
      disp_q      <= disp_d;
      tag_q       <= tag_d;
      pc_q        <= pc_d;
      vgpr_q      <= vgpr_d;
      sgpr_q      <= sgpr_d;
      lds_q       <= lds_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      free_q      <= free_d;
      err_q       <= err_d;
    end
  end

  assign dispatch2cu_wf_dispatch        = disp_q;
  assign dispatch2cu_wf_tag_dispatch    = tag_q;
  assign dispatch2cu_start_pc_dispatch  = pc_q;
  assign dispatch2cu_vgpr_base_dispatch = vgpr_q;
  assign dispatch2cu_sgpr_base_dispatch = sgpr_q;
  assign dispatch2cu_lds_base_dispatch  = lds_q;
  assign dispatch2cu_wf_size_dispatch   = size_q;
  assign dispatch2cu_wg_wf_count        = cnt_q;
  assign free_wf_slots                  = free_q;
  assign err_flags                      = err_q;

endmodule

// File: tb/tb_cu_wf_dispatcher.sv
// Self-checking bench for cu_wf_dispatcher: directed scenarios plus
// randomized workgroups against a credit/outstanding-wavefront model.
module tb_cu_wf_dispatcher;

  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wg_valid;
  logic        wg_ready;
  logic [10:0] wg_id;
  logic [3:0]  wg_wf_count;
  logic [31:0] wg_start_pc;
  logic [9:0]  wg_vgpr_base;
  logic [8:0]  wg_sgpr_base;
  logic [15:0] wg_lds_base;
  logic [5:0]  wg_wf_size;
  logic [9:0]  wg_vgpr_stride;
  logic [8:0]  wg_sgpr_stride;
  logic        d_disp;
  logic [14:0] d_tag;
  logic [31:0] d_pc;
  logic [9:0]  d_vgpr;
  logic [8:0]  d_sgpr;
  logic [15:0] d_lds;
  logic [5:0]  d_size;
  logic [3:0]  d_cnt;
  logic        done_v;
  logic [14:0] done_tag;
  logic        wg_done;
  logic [10:0] wg_done_id;
  logic [5:0]  free_wf_slots;
  logic [1:0]  err_flags;

  always #5 clk = ~clk;

  cu_wf_dispatcher #(.NUM_WG_SLOTS(4), .NUM_WF_SLOTS(40), .DISPATCH_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .wg_valid(wg_valid), .wg_ready(wg_ready), .wg_id(wg_id), .wg_wf_count(wg_wf_count),
    .wg_start_pc(wg_start_pc), .wg_vgpr_base(wg_vgpr_base), .wg_sgpr_base(wg_sgpr_base),
    .wg_lds_base(wg_lds_base), .wg_wf_size(wg_wf_size),
    .wg_vgpr_stride(wg_vgpr_stride), .wg_sgpr_stride(wg_sgpr_stride),
    .dispatch2cu_wf_dispatch(d_disp), .dispatch2cu_wf_tag_dispatch(d_tag),
    .dispatch2cu_start_pc_dispatch(d_pc), .dispatch2cu_vgpr_base_dispatch(d_vgpr),
    .dispatch2cu_sgpr_base_dispatch(d_sgpr), .dispatch2cu_lds_base_dispatch(d_lds),
    .dispatch2cu_wf_size_dispatch(d_size), .dispatch2cu_wg_wf_count(d_cnt),
    .cu2dispatch_wf_done(done_v), .cu2dispatch_wf_tag_done(done_tag),
    .wg_done(wg_done), .wg_done_id(wg_done_id),
    .free_wf_slots(free_wf_slots), .err_flags(err_flags)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: wavefronts dispatched but not yet reported done, per workgroup id.
  int outstanding[int];

  // Observed dispatch pulses from the latest collect() window.
  int          q_off[$];
  logic [14:0] q_tag[$];
  logic [9:0]  q_vgpr[$];
  logic [8:0]  q_sgpr[$];
  logic [31:0] q_pc[$];
  logic [15:0] q_lds[$];
  logic [5:0]  q_size[$];
  logic [3:0]  q_cnt[$];

  function automatic int model_free();
    int s;
    s = 40;
    foreach (outstanding[k]) s = s - outstanding[k];
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wg_valid = 1'b0; wg_id = '0; wg_wf_count = '0; wg_start_pc = '0;
    wg_vgpr_base = '0; wg_sgpr_base = '0; wg_lds_base = '0; wg_wf_size = '0;
    wg_vgpr_stride = '0; wg_sgpr_stride = '0; done_v = 1'b0; done_tag = '0;
  endtask

  // Offer a descriptor until accepted or max_wait cycles pass; returns at
  // the negedge just after the accepting edge.
  task automatic offer(input logic [10:0] id, input logic [3:0] cnt, input logic [31:0] pc,
                       input logic [9:0] vb, input logic [8:0] sb, input logic [15:0] lds,
                       input logic [5:0] sz, input logic [9:0] vs, input logic [8:0] ss,
                       input int max_wait, output bit ok);
    ok = 1'b0;
    tick();
    wg_valid = 1'b1; wg_id = id; wg_wf_count = cnt; wg_start_pc = pc;
    wg_vgpr_base = vb; wg_sgpr_base = sb; wg_lds_base = lds; wg_wf_size = sz;
    wg_vgpr_stride = vs; wg_sgpr_stride = ss;
    for (int c = 0; c < max_wait && !ok; c++) begin
      #1;
      if (wg_ready === 1'b1) ok = 1'b1;
      tick();
    end
    wg_valid = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    q_off.delete(); q_tag.delete(); q_vgpr.delete(); q_sgpr.delete();
    q_pc.delete(); q_lds.delete(); q_size.delete(); q_cnt.delete();
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (d_disp === 1'b1) begin
        q_off.push_back(c); q_tag.push_back(d_tag); q_vgpr.push_back(d_vgpr);
        q_sgpr.push_back(d_sgpr); q_pc.push_back(d_pc); q_lds.push_back(d_lds);
        q_size.push_back(d_size); q_cnt.push_back(d_cnt);
      end
    end
  endtask

  // Present one done tag for a single cycle; returns with its effect visible.
  task automatic send_done(input logic [14:0] tag);
    done_v = 1'b1; done_tag = tag;
    tick();
    done_v = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (d_disp !== 1'b0) $display("FAIL reset_dispatch: got %b expected 0", d_disp); else n_pass++;
    n_checks++; if (d_tag !== 15'd0) $display("FAIL reset_tag: got %h expected 0", d_tag); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'd40) $display("FAIL reset_free: got %0d expected 40", free_wf_slots); else n_pass++;
    n_checks++; if (err_flags !== 2'b00) $display("FAIL reset_err: got %b expected 00", err_flags); else n_pass++;
    n_checks++; if (wg_done !== 1'b0) $display("FAIL reset_wg_done: got %b expected 0", wg_done); else n_pass++;
    rst = 1'b1;
    tick();
    #1;
    n_checks++; if (wg_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", wg_ready); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'd40) $display("FAIL post_reset_free: got %0d expected 40", free_wf_slots); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    int exp_off[3] = '{1, 3, 5};
    logic [14:0] exp_tag[3] = '{15'h050, 15'h051, 15'h052};
    logic [9:0]  exp_v[3]   = '{10'd16, 10'd24, 10'd32};
    offer(11'd5, 4'd3, 32'h0000_1000, 10'd16, 9'd4, 16'h0020, 6'd63, 10'd8, 9'd2, 10, ok);
    n_checks++; if (!ok) $display("FAIL basic_accept: got not-ready expected ready"); else n_pass++;
    collect(8);
    n_checks++; if (q_off.size() != 3) $display("FAIL basic_pulse_count: got %0d expected 3", q_off.size()); else n_pass++;
    for (int k = 0; k < 3 && k < q_off.size(); k++) begin
      n_checks++; if (q_off[k] != exp_off[k]) $display("FAIL basic_offset%0d: got %0d expected %0d", k, q_off[k], exp_off[k]); else n_pass++;
      n_checks++; if (q_tag[k] !== exp_tag[k] || q_vgpr[k] !== exp_v[k])
        $display("FAIL basic_fields%0d: got tag %h vgpr %0d expected tag %h vgpr %0d", k, q_tag[k], q_vgpr[k], exp_tag[k], exp_v[k]);
      else n_pass++;
    end
    outstanding[5] = 3;
    n_checks++; if (free_wf_slots !== 6'(model_free())) $display("FAIL basic_free: got %0d expected %0d", free_wf_slots, model_free()); else n_pass++;
    send_done(15'h052);
    n_checks++; if (wg_done !== 1'b0) $display("FAIL basic_early_done1: got %b expected 0", wg_done); else n_pass++;
    send_done(15'h050);
    n_checks++; if (wg_done !== 1'b0) $display("FAIL basic_early_done2: got %b expected 0", wg_done); else n_pass++;
    send_done(15'h051);
    outstanding.delete(5);
    n_checks++; if (wg_done !== 1'b1 || wg_done_id !== 11'd5) $display("FAIL basic_wg_done: got %b id %0d expected 1 id 5", wg_done, wg_done_id); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'd40) $display("FAIL basic_free_restored: got %0d expected 40", free_wf_slots); else n_pass++;
    tick();
    n_checks++; if (wg_done !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", wg_done); else n_pass++;
  endtask

  task automatic test_random_workgroups();
    for (int it = 0; it < 6; it++) begin
      bit ok;
      int n_wg_done;
      int order[15];
      logic [10:0] id  = 11'($urandom_range(1, 11'h7FE));
      logic [3:0]  cnt = 4'($urandom_range(1, 15));
      logic [31:0] pc  = $urandom;
      logic [9:0]  vb  = 10'($urandom);
      logic [8:0]  sb  = 9'($urandom);
      logic [15:0] lds = 16'($urandom);
      logic [5:0]  sz  = 6'($urandom);
      logic [9:0]  vs  = 10'($urandom);
      logic [8:0]  ss  = 9'($urandom);
      offer(id, cnt, pc, vb, sb, lds, sz, vs, ss, 10, ok);
      n_checks++; if (!ok) $display("FAIL rand_accept%0d: got not-ready expected ready", it); else n_pass++;
      collect(int'(cnt) * (GAP + 1) + 4);
      n_checks++; if (q_off.size() != int'(cnt)) $display("FAIL rand_count%0d: got %0d expected %0d", it, q_off.size(), cnt); else n_pass++;
      for (int k = 0; k < int'(cnt) && k < q_off.size(); k++) begin
        logic [3:0]  kk    = 4'(k);
        logic [14:0] e_tag = {id, kk};
        logic [9:0]  e_v   = 10'((int'(vb) + k * int'(vs)) % 1024);
        logic [8:0]  e_s   = 9'((int'(sb) + k * int'(ss)) % 512);
        logic [91:0] exp_w = {e_tag, e_v, e_s, pc, lds, sz, cnt};
        logic [91:0] got_w = {q_tag[k], q_vgpr[k], q_sgpr[k], q_pc[k], q_lds[k], q_size[k], q_cnt[k]};
        n_checks++; if (q_off[k] != 1 + k * (GAP + 1)) $display("FAIL rand_offset%0d_%0d: got %0d expected %0d", it, k, q_off[k], 1 + k * (GAP + 1)); else n_pass++;
        n_checks++; if (got_w !== exp_w) $display("FAIL rand_fields%0d_%0d: got %h expected %h", it, k, got_w, exp_w); else n_pass++;
      end
      outstanding[int'(id)] = int'(cnt);
      n_checks++; if (free_wf_slots !== 6'(model_free())) $display("FAIL rand_free%0d: got %0d expected %0d", it, free_wf_slots, model_free()); else n_pass++;
      for (int k = 0; k < 15; k++) order[k] = k;
      for (int k = int'(cnt) - 1; k > 0; k--) begin
        int j = $urandom_range(0, k);
        int t = order[k];
        order[k] = order[j];
        order[j] = t;
      end
      n_wg_done = 0;
      for (int k = 0; k < int'(cnt); k++) begin
        logic [3:0] wi = 4'(order[k]);
        send_done({id, wi});
        outstanding[int'(id)] = outstanding[int'(id)] - 1;
        if (wg_done === 1'b1) n_wg_done++;
      end
      outstanding.delete(int'(id));
      n_checks++; if (n_wg_done != 1 || wg_done_id !== id) $display("FAIL rand_wg_done%0d: got %0d pulses id %0d expected 1 id %0d", it, n_wg_done, wg_done_id, id); else n_pass++;
      n_checks++; if (free_wf_slots !== 6'(model_free())) $display("FAIL rand_free_back%0d: got %0d expected %0d", it, free_wf_slots, model_free()); else n_pass++;
    end
  endtask

  task automatic test_cam_full();
    bit ok;
    int n_seen;
    for (int j = 0; j < 4; j++) begin
      offer(11'(100 + j), 4'd1, 32'h100, 10'd0, 9'd0, 16'd0, 6'd1, 10'd1, 9'd1, 10, ok);
      collect(3);
      outstanding[100 + j] = 1;
      n_checks++; if (!ok || q_off.size() != 1) $display("FAIL cam_fill%0d: got accepted %0d pulses %0d expected 1 and 1", j, ok, q_off.size()); else n_pass++;
    end
    n_checks++; if (free_wf_slots !== 6'(model_free())) $display("FAIL cam_free: got %0d expected %0d", free_wf_slots, model_free()); else n_pass++;
    tick();
    wg_valid = 1'b1; wg_id = 11'd104; wg_wf_count = 4'd1;
    n_seen = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (wg_ready !== 1'b0) n_seen++;
      tick();
    end
    n_checks++; if (n_seen != 0) $display("FAIL cam_full_ready: got %0d ready cycles expected 0", n_seen); else n_pass++;
    send_done({11'd100, 4'd0});
    outstanding.delete(100);
    #1;
    n_checks++; if (wg_done !== 1'b1 || wg_done_id !== 11'd100) $display("FAIL cam_done: got %b id %0d expected 1 id 100", wg_done, wg_done_id); else n_pass++;
    n_checks++; if (wg_ready !== 1'b1) $display("FAIL cam_ready_after_free: got %b expected 1", wg_ready); else n_pass++;
    tick();
    wg_valid = 1'b0;
    collect(3);
    outstanding[104] = 1;
    n_checks++; if (q_tag.size() != 1 || q_tag[0] !== {11'd104, 4'd0}) $display("FAIL cam_fifth_dispatch: got %0d pulses expected 1 with tag %h", q_tag.size(), {11'd104, 4'd0}); else n_pass++;
    for (int j = 101; j <= 104; j++) begin
      send_done({11'(j), 4'd0});
      outstanding.delete(j);
    end
    n_checks++; if (free_wf_slots !== 6'(model_free())) $display("FAIL cam_free_end: got %0d expected %0d", free_wf_slots, model_free()); else n_pass++;
  endtask

  task automatic test_credit_limit();
    bit ok;
    int n_seen;
    int ids[4]  = '{200, 201, 202, 203};
    int cnts[4] = '{15, 15, 8, 2};
    for (int j = 0; j < 3; j++) begin
      offer(11'(ids[j]), 4'(cnts[j]), 32'h200, 10'd0, 9'd0, 16'd0, 6'd2, 10'd1, 9'd1, 10, ok);
      collect(cnts[j] * (GAP + 1) + 3);
      outstanding[ids[j]] = cnts[j];
      n_checks++; if (!ok || q_off.size() != cnts[j]) $display("FAIL credit_fill%0d: got accepted %0d pulses %0d expected 1 and %0d", j, ok, q_off.size(), cnts[j]); else n_pass++;
    end
    n_checks++; if (free_wf_slots !== 6'd2) $display("FAIL credit_two_left: got %0d expected 2", free_wf_slots); else n_pass++;
    tick();
    wg_valid = 1'b1; wg_id = 11'd203; wg_wf_count = 4'd3;
    n_seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (wg_ready !== 1'b0) n_seen++;
      tick();
    end
    n_checks++; if (n_seen != 0) $display("FAIL credit_ready_low: got %0d ready cycles expected 0", n_seen); else n_pass++;
    wg_wf_count = 4'd2;
    #1;
    n_checks++; if (wg_ready !== 1'b1) $display("FAIL credit_ready_fit: got %b expected 1", wg_ready); else n_pass++;
    tick();
    wg_valid = 1'b0;
    send_done({11'd200, 4'd0});
    outstanding[200] = 14;
    n_checks++; if (d_disp !== 1'b1 || free_wf_slots !== 6'd2) $display("FAIL credit_simultaneous: got pulse %b free %0d expected 1 and 2", d_disp, free_wf_slots); else n_pass++;
    collect(4);
    outstanding[203] = 2;
    n_checks++; if (q_off.size() != 1 || free_wf_slots !== 6'(model_free())) $display("FAIL credit_second_pulse: got %0d pulses free %0d expected 1 and %0d", q_off.size(), free_wf_slots, model_free()); else n_pass++;
    n_seen = 0;
    for (int j = 0; j < 4; j++) begin
      for (int k = (j == 0) ? 1 : 0; k < cnts[j]; k++) begin
        send_done({11'(ids[j]), 4'(k)});
        if (wg_done === 1'b1) n_seen++;
      end
      outstanding.delete(ids[j]);
    end
    n_checks++; if (n_seen != 4) $display("FAIL credit_wg_done_count: got %0d expected 4", n_seen); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'(model_free())) $display("FAIL credit_free_end: got %0d expected %0d", free_wf_slots, model_free()); else n_pass++;
  endtask

  task automatic test_errors();
    bit ok;
    tick();
    send_done(15'h7FF0);
    n_checks++; if (err_flags !== 2'b01) $display("FAIL err_unknown_tag: got %b expected 01", err_flags); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'd40) $display("FAIL err_credit_kept: got %0d expected 40", free_wf_slots); else n_pass++;
    offer(11'd400, 4'd0, 32'h400, 10'd0, 9'd0, 16'd0, 6'd0, 10'd0, 9'd0, 10, ok);
    n_checks++; if (!ok) $display("FAIL err_zero_accept: got not-ready expected ready"); else n_pass++;
    n_checks++; if (err_flags !== 2'b11) $display("FAIL err_zero_count: got %b expected 11", err_flags); else n_pass++;
    collect(6);
    n_checks++; if (q_off.size() != 0) $display("FAIL err_zero_no_pulse: got %0d expected 0", q_off.size()); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'd40) $display("FAIL err_zero_credit: got %0d expected 40", free_wf_slots); else n_pass++;
  endtask

  task automatic test_reset_mid_sequence();
    bit ok;
    offer(11'd300, 4'd4, 32'h300, 10'd10, 9'd10, 16'd0, 6'd4, 10'd3, 9'd3, 10, ok);
    collect(3);
    n_checks++; if (!ok || q_off.size() != 2) $display("FAIL rstmid_two_pulses: got accepted %0d pulses %0d expected 1 and 2", ok, q_off.size()); else n_pass++;
    #2 rst = 1'b0;
    #1;
    outstanding.delete();
    n_checks++; if (d_disp !== 1'b0 || d_tag !== 15'd0 || d_vgpr !== 10'd0) $display("FAIL rstmid_async_clear: got pulse %b tag %h vgpr %0d expected all 0", d_disp, d_tag, d_vgpr); else n_pass++;
    n_checks++; if (free_wf_slots !== 6'd40 || err_flags !== 2'b00) $display("FAIL rstmid_free_err: got free %0d err %b expected 40 and 00", free_wf_slots, err_flags); else n_pass++;
    tick();
    rst = 1'b1;
    collect(12);
    n_checks++; if (q_off.size() != 0) $display("FAIL rstmid_no_more_pulses: got %0d expected 0", q_off.size()); else n_pass++;
    wg_id = 11'd300; wg_wf_count = 4'd4;
    #1;
    n_checks++; if (wg_ready !== 1'b1 || free_wf_slots !== 6'd40) $display("FAIL rstmid_cam_cleared: got ready %b free %0d expected 1 and 40", wg_ready, free_wf_slots); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_random_workgroups();
    test_cam_full();
    test_credit_limit();
    test_errors();
    test_reset_mid_sequence();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
